// File: rtl/vending_pkg.sv
// Types shared between the coin front end and the candy vending FSM.
// Coin codes map directly onto the FSM's In input.
package vending_pkg;

  typedef enum logic {
    COIN_RE1 = 1'b0,
    COIN_RS2 = 1'b1
  } coin_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_CLASSIFY,
    ST_STUCK
  } cls_state_t;

endpackage

// File: rtl/coin_classifier_if.sv
// Coin chute sensor in, classified coin strobes out.
// master = classifier side, slave = consumer / stimulus side.
interface coin_classifier_if;
  logic coin_sense;
  logic coin_valid;
  logic coin_val;
  logic coin_reject;
  logic busy;

  modport master (
    input  coin_sense,
    output coin_valid,
    output coin_val,
    output coin_reject,
    output busy
  );

  modport slave (
    output coin_sense,
    input  coin_valid,
    input  coin_val,
    input  coin_reject,
    input  busy
  );
endinterface

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus debouncer; deb follows the sensor 2+DEB cycles late.
// No backpressure: free-running, one level change per DEB stable samples.
module coin_debounce #(
  parameter int DEB = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_sense,
  output logic deb
);

  localparam int CW = $clog2(DEB + 1);

  logic          s_meta;
  logic          s_sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      deb    <= 1'b0;
      cnt    <= '0;
    end else begin
      s_meta <= coin_sense;
      s_sync <= s_meta;
      if (s_sync == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB - 1)) begin
        // This sample is the DEB-th consecutive disagreement.
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_classifier.sv
// Measures debounced coin pulse width and classifies it as Re1 / Rs2 / reject.
// Strobe appears 2+DEB+1 cycles after the raw fall; no backpressure, one strobe per coin.
module coin_classifier
  import vending_pkg::*;
#(
  parameter int DEB     = 4,
  parameter int CNT_W   = 8,
  parameter int RE1_MIN = 8,
  parameter int RE1_MAX = 15,
  parameter int RS2_MIN = 24,
  parameter int RS2_MAX = 40
) (
  input logic               clk,
  input logic               rst,
  coin_classifier_if.master cif
);

  localparam logic [CNT_W-1:0] W_MAX  = '1;
  localparam logic [CNT_W-1:0] W_NEAR = W_MAX - 1'b1;
  localparam logic [CNT_W-1:0] R1_LO  = CNT_W'(RE1_MIN);
  localparam logic [CNT_W-1:0] R1_HI  = CNT_W'(RE1_MAX);
  localparam logic [CNT_W-1:0] R2_LO  = CNT_W'(RS2_MIN);
  localparam logic [CNT_W-1:0] R2_HI  = CNT_W'(RS2_MAX);

  logic             deb;
  cls_state_t       state;
  logic [CNT_W-1:0] width;
  logic             valid_q;
  logic             reject_q;
  logic             busy_q;
  coin_t            val_q;

  coin_debounce #(.DEB(DEB)) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .coin_sense (cif.coin_sense),
    .deb        (deb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      width    <= '0;
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
      val_q    <= COIN_RE1;
    end else begin
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
      unique case (state)
        // IDLE is only ever entered with deb low, so a high level here is a rising edge.
        ST_IDLE: begin
          if (deb) begin
            width  <= CNT_W'(1);
            state  <= ST_MEASURE;
            busy_q <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (deb) begin
            if (width == W_NEAR) begin
              width    <= W_MAX;
              reject_q <= 1'b1;
              state    <= ST_STUCK;
            end else begin
              width <= width + 1'b1;
            end
          end else begin
            state <= ST_CLASSIFY;
            if (width >= R1_LO && width <= R1_HI) begin
              valid_q <= 1'b1;
              val_q   <= COIN_RE1;
            end else if (width >= R2_LO && width <= R2_HI) begin
              valid_q <= 1'b1;
              val_q   <= COIN_RS2;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        ST_CLASSIFY: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        ST_STUCK: begin
          if (!deb) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign cif.coin_valid  = valid_q;
  assign cif.coin_val    = val_q;
  assign cif.coin_reject = reject_q;
  assign cif.busy        = busy_q;

endmodule
